// File: rtl/fetch_exec_sequencer_if.sv
// Control-path bus between the fetch/execute sequencer and its memory/datapath side.
// The master side drives start, memory response and exec_done; the slave side is the sequencer.
interface fetch_exec_sequencer_if #(
  parameter int IR_W   = 16,
  parameter int BYTE_W = 8,
  parameter int OPC_W  = 4,
  parameter int T_MAX  = 8
);
  logic                  start;
  logic                  mem_ready;
  logic [BYTE_W-1:0]     mem_rdata;
  logic                  exec_done;
  logic                  mem_rd;
  logic                  pc_inc;
  logic [IR_W-1:0]       ir;
  logic [T_MAX-1:0]      t_onehot;
  logic [2**OPC_W-1:0]   opc_onehot;
  logic                  busy;
  logic                  halted;
  logic                  t_overflow;

  modport master (
    output start, mem_ready, mem_rdata, exec_done,
    input  mem_rd, pc_inc, ir, t_onehot, opc_onehot, busy, halted, t_overflow
  );

  modport slave (
    input  start, mem_ready, mem_rdata, exec_done,
    output mem_rd, pc_inc, ir, t_onehot, opc_onehot, busy, halted, t_overflow
  );
endinterface

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle CPU sequencer: byte-wise instruction fetch with ready handshake, one-cycle
// decode and a variable-length execute phase, exposing one-hot T-state and opcode vectors.
module fetch_exec_sequencer #(
  parameter int IR_W   = 16,
  parameter int BYTE_W = 8,
  parameter int OPC_W  = 4,
  parameter int T_MAX  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fetch_exec_sequencer_if.slave  bus
);
  localparam int NB   = IR_W / BYTE_W;
  localparam int SC_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int FB_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int OH_W = 2**OPC_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            state, state_nx;
  logic [SC_W-1:0]   sc, sc_nx;
  logic [FB_W-1:0]   fb, fb_nx;
  logic [IR_W-1:0]   ir_q, ir_nx;
  logic              ovf_q, ovf_nx;
  logic              in_fetch;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sc    <= '0;
      fb    <= '0;
      ir_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      sc    <= sc_nx;
      fb    <= fb_nx;
      ir_q  <= ir_nx;
      ovf_q <= ovf_nx;
    end
  end

  // NOTE: every next-state value is defaulted to its current value first, so no path infers a latch.
  always_comb begin
    state_nx = state;
    sc_nx    = sc;
    fb_nx    = fb;
    ir_nx    = ir_q;
    ovf_nx   = ovf_q;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        // Wait states simply hold everything until memory answers.
        if (bus.mem_ready) begin
          ir_nx[int'(fb)*BYTE_W +: BYTE_W] = bus.mem_rdata;
          sc_nx = sc + SC_W'(1);
          if (fb == FB_W'(NB-1)) begin
            fb_nx    = '0;
            state_nx = S_DECODE;
          end else begin
            fb_nx = fb + FB_W'(1);
          end
        end
      end
      S_DECODE: begin
        if (&ir_q) begin
          state_nx = S_HALT;
        end else begin
          sc_nx    = SC_W'(NB+1);
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        // exec_done takes priority, so the last legal T state can still finish cleanly.
        if (bus.exec_done) begin
          sc_nx    = '0;
          state_nx = S_FETCH;
        end else if (sc == SC_W'(T_MAX-1)) begin
          ovf_nx   = 1'b1;
          state_nx = S_HALT;
        end else begin
          sc_nx = sc + SC_W'(1);
        end
      end
      S_HALT: ;
      default: state_nx = S_IDLE;
    endcase
  end

  assign in_fetch       = (state == S_FETCH);
  assign bus.mem_rd     = in_fetch;
  assign bus.pc_inc     = in_fetch & bus.mem_ready;
  assign bus.ir         = ir_q;
  assign bus.busy       = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign bus.halted     = (state == S_HALT);
  assign bus.t_overflow = ovf_q;
  assign bus.t_onehot   = bus.busy ? (T_MAX'(1) << sc) : '0;
  assign bus.opc_onehot = ((state == S_DECODE) || (state == S_EXEC))
                          ? (OH_W'(1) << ir_q[IR_W-1 -: OPC_W]) : '0;
endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed bench for fetch_exec_sequencer: fetch with and without wait states, execute
// length, halt opcode, T-state overflow and asynchronous reset, against hand-computed values.
module tb_fetch_exec_sequencer;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   rd_cnt;
  int   inc_cnt;

  fetch_exec_sequencer_if bus ();

  fetch_exec_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch2(input logic [7:0] lo, input logic [7:0] hi);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = lo;
    tick();
    bus.mem_rdata = hi;
    tick();
    bus.mem_ready = 1'b0;
    #1;
  endtask

  task automatic start_fetch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy"},   64'(bus.busy),       64'h0);
    check({tag, ".ir"},     64'(bus.ir),         64'h0);
    check({tag, ".t"},      64'(bus.t_onehot),   64'h0);
    check({tag, ".opc"},    64'(bus.opc_onehot), 64'h0);
    check({tag, ".mem_rd"}, 64'(bus.mem_rd),     64'h0);
    check({tag, ".halted"}, 64'(bus.halted),     64'h0);
    check({tag, ".ovf"},    64'(bus.t_overflow), 64'h0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    bus.exec_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_idle_zero("reset");

    // No-wait fetch of 16'h1234
    start_fetch();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h34;
    #1;
    check("nw.mem_rd0", 64'(bus.mem_rd),   64'h1);
    check("nw.pc_inc0", 64'(bus.pc_inc),   64'h1);
    check("nw.t0",      64'(bus.t_onehot), 64'h1);
    tick();
    bus.mem_rdata = 8'h12;
    #1;
    check("nw.pc_inc1", 64'(bus.pc_inc),   64'h1);
    check("nw.t1",      64'(bus.t_onehot), 64'h2);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    check("dec.t",      64'(bus.t_onehot),   64'h4);
    check("dec.opc",    64'(bus.opc_onehot), 64'h0002);
    check("dec.ir",     64'(bus.ir),         64'h1234);
    check("dec.pc_inc", 64'(bus.pc_inc),     64'h0);
    bus.mem_ready = 1'b0;

    // Execute until exec_done at SC=5
    tick();
    check("exec.t3", 64'(bus.t_onehot), 64'h08);
    tick();
    check("exec.t4", 64'(bus.t_onehot), 64'h10);
    tick();
    check("exec.t5", 64'(bus.t_onehot), 64'h20);
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    #1;
    check("ret.t",      64'(bus.t_onehot),   64'h1);
    check("ret.mem_rd", 64'(bus.mem_rd),     64'h1);
    check("ret.opc",    64'(bus.opc_onehot), 64'h0);

    // Back-to-back fetch with three wait states before each byte (16'h5678)
    rd_cnt  = 0;
    inc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = (i == 3) || (i == 7);
      bus.mem_rdata = (i < 4) ? 8'h78 : 8'h56;
      #1;
      if (bus.mem_rd) rd_cnt++;
      if (bus.pc_inc) inc_cnt++;
      check($sformatf("ws.t%0d", i), 64'(bus.t_onehot), (i < 4) ? 64'h1 : 64'h2);
      tick();
    end
    bus.mem_ready = 1'b0;
    #1;
    check("ws.rd_cycles", 64'(rd_cnt),         64'd8);
    check("ws.pulses",    64'(inc_cnt),        64'd2);
    check("ws.ir",        64'(bus.ir),         64'h5678);
    check("ws.opc",       64'(bus.opc_onehot), 64'h0020);
    check("ws.dec_t",     64'(bus.t_onehot),   64'h4);

    // Asynchronous reset in the middle of EXEC, no clock edge in between
    tick();
    check("pre_rst.t", 64'(bus.t_onehot), 64'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("async_rst");
    tick();
    rst_n = 1'b1;
    #1;

    // Overflow: exec_done never asserted
    start_fetch();
    fetch2(8'h00, 8'h20);
    check("ov.opc", 64'(bus.opc_onehot), 64'h0004);
    for (int i = 3; i <= 7; i++) begin
      tick();
      check($sformatf("ov.t%0d", i), 64'(bus.t_onehot), 64'(1) << i);
    end
    check("ov.pre_flag", 64'(bus.t_overflow), 64'h0);
    tick();
    check("ov.flag",   64'(bus.t_overflow), 64'h1);
    check("ov.halted", 64'(bus.halted),     64'h1);
    check("ov.busy",   64'(bus.busy),       64'h0);
    check("ov.t",      64'(bus.t_onehot),   64'h0);
    bus.start     = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check("ov.pc_inc", 64'(bus.pc_inc), 64'h0);
    tick();
    tick();
    check("ov.stays", 64'(bus.halted),     64'h1);
    check("ov.ir",    64'(bus.ir),         64'h2000);
    check("ov.hold",  64'(bus.t_overflow), 64'h1);
    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_zero("rst2");
    tick();
    rst_n = 1'b1;
    #1;

    // exec_done on the last T state wins over overflow
    start_fetch();
    fetch2(8'h11, 8'h30);
    for (int i = 3; i <= 7; i++) tick();
    check("edge.t7", 64'(bus.t_onehot), 64'h80);
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    #1;
    check("edge.ovf",    64'(bus.t_overflow), 64'h0);
    check("edge.t",      64'(bus.t_onehot),   64'h1);
    check("edge.mem_rd", 64'(bus.mem_rd),     64'h1);

    // All-ones instruction halts straight from DECODE
    fetch2(8'hFF, 8'hFF);
    check("halt.dec_busy", 64'(bus.busy),       64'h1);
    check("halt.dec_opc",  64'(bus.opc_onehot), 64'h8000);
    tick();
    check("halt.halted", 64'(bus.halted),     64'h1);
    check("halt.busy",   64'(bus.busy),       64'h0);
    check("halt.t",      64'(bus.t_onehot),   64'h0);
    check("halt.opc",    64'(bus.opc_onehot), 64'h0);
    check("halt.ovf",    64'(bus.t_overflow), 64'h0);
    bus.start     = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h00;
    tick();
    tick();
    check("halt.stays",  64'(bus.halted), 64'h1);
    check("halt.mem_rd", 64'(bus.mem_rd), 64'h0);
    check("halt.pc_inc", 64'(bus.pc_inc), 64'h0);
    check("halt.ir",     64'(bus.ir),     64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
